// File: rtl/ht_res_stat_pkg.sv
// ht_res_stat_pkg
//   Shared types and constants for the hash table result path and the
//   result statistics block.
//   - KEY_WIDTH / VALUE_WIDTH : width of result key and value fields
//   - ht_cmd_t                : command that produced the result
//   - ht_res_t                : result code (7 defined codes, 3-bit encoding)
//   - HT_RES_NUM_CODES        : number of defined result codes
//   - HT_RES_STAT_ADDR_TOTAL  : statistics read address of the total counter
package ht_res_stat_pkg;

  localparam int KEY_WIDTH   = 16;
  localparam int VALUE_WIDTH = 16;

  typedef enum logic [1:0] {
    CMD_SEARCH = 2'd0,
    CMD_INSERT = 2'd1,
    CMD_DELETE = 2'd2
  } ht_cmd_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                   = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
  } ht_res_t;

  localparam int         HT_RES_NUM_CODES       = 7;
  localparam logic [2:0] HT_RES_STAT_ADDR_TOTAL = 3'd7;

endpackage

// File: rtl/ht_res_if.sv
// ht_res_if
//   Valid/ready result channel out of the hash table.
//   - key, value, cmd, res : result payload
//   - valid                : payload present (producer -> consumer)
//   - ready                : consumer can take the payload (consumer -> producer)
interface ht_res_if;
  import ht_res_stat_pkg::*;

  logic [KEY_WIDTH-1:0]   key;
  logic [VALUE_WIDTH-1:0] value;
  ht_cmd_t                cmd;
  ht_res_t                res;
  logic                   valid;
  logic                   ready;

  modport master (output key, output value, output cmd, output res, output valid, input ready);
  modport slave  (input key, input value, input cmd, input res, input valid, output ready);
endinterface

// File: rtl/ht_sat_cnt.sv
// ht_sat_cnt
//   Saturating event counter with synchronous clear.
//   - clk, srst : clock and synchronous active-high reset
//   - inc       : count one event this cycle
//   - clr       : zero the counter; an event in the same cycle still counts
//   - value     : current count, sticks at all-ones
module ht_sat_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] value
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      value_reg <= '0;
    end else if (clr) begin
      // Clear restarts from the coincident event so it is not lost.
      value_reg <= inc ? CNT_ONE : '0;
    end else if (inc && (value_reg != CNT_MAX)) begin
      value_reg <= value_reg + CNT_ONE;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/ht_res_stat.sv
// ht_res_stat
//   Result-stream register slice with per-result-code statistics.
//   - clk_i, rst_i   : clock, synchronous active-high reset
//   - ht_res_in      : results from the hash table (we drive ready)
//   - ht_res_out     : results to the consumer
//   - stat_rd_en_i   : read strobe, stat_rd_addr_i selects code 0..6 or 7 = total
//   - stat_rd_data_o : registered read data, holds between reads
//   - stat_rd_val_o  : one-cycle pulse marking fresh read data
//   - stat_clr_i     : clear every counter
//   SLICE_EN=1 registers the stream (1-cycle latency, full throughput);
//   SLICE_EN=0 passes it straight through and only counts.
module ht_res_stat
  import ht_res_stat_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter bit SLICE_EN  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ht_res_if.slave              ht_res_in,
  ht_res_if.master             ht_res_out,
  input  logic                 stat_rd_en_i,
  input  logic [2:0]           stat_rd_addr_i,
  output logic [CNT_WIDTH-1:0] stat_rd_data_o,
  output logic                 stat_rd_val_o,
  input  logic                 stat_clr_i
);

  logic                 in_ready;
  logic                 in_xfer;
  logic [2:0]           res_code;
  logic [CNT_WIDTH-1:0] cnt [0:7];
  logic [CNT_WIDTH-1:0] rd_data_reg;
  logic                 rd_val_reg;

  assign ht_res_in.ready = in_ready;
  assign in_xfer         = ht_res_in.valid & in_ready;
  assign res_code        = ht_res_in.res;

  // ---------------------------------------------------------------- data path
  generate
    if (SLICE_EN) begin : g_slice
      logic                   valid_reg;
      logic [KEY_WIDTH-1:0]   key_reg;
      logic [VALUE_WIDTH-1:0] value_reg;
      ht_cmd_t                cmd_reg;
      ht_res_t                res_reg;

      // Accept when empty or when the held beat leaves this cycle.
      assign in_ready = ~valid_reg | ht_res_out.ready;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_reg <= 1'b0;
          key_reg   <= '0;
          value_reg <= '0;
          cmd_reg   <= ht_cmd_t'(2'd0);
          res_reg   <= ht_res_t'(3'd0);
        end else if (in_xfer) begin
          valid_reg <= 1'b1;
          key_reg   <= ht_res_in.key;
          value_reg <= ht_res_in.value;
          cmd_reg   <= ht_res_in.cmd;
          res_reg   <= ht_res_in.res;
        end else if (ht_res_out.ready) begin
          valid_reg <= 1'b0;
        end
      end

      assign ht_res_out.valid = valid_reg;
      assign ht_res_out.key   = key_reg;
      assign ht_res_out.value = value_reg;
      assign ht_res_out.cmd   = cmd_reg;
      assign ht_res_out.res   = res_reg;
    end else begin : g_wire
      assign in_ready         = ht_res_out.ready;
      assign ht_res_out.valid = ht_res_in.valid;
      assign ht_res_out.key   = ht_res_in.key;
      assign ht_res_out.value = ht_res_in.value;
      assign ht_res_out.cmd   = ht_res_in.cmd;
      assign ht_res_out.res   = ht_res_in.res;
    end
  endgenerate

  // ---------------------------------------------------------------- counters
  // One counter per defined code; code 7 has none, so slot 7 holds the total.
  generate
    for (genvar gi = 0; gi < HT_RES_NUM_CODES; gi++) begin : g_code_cnt
      ht_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk   (clk_i),
        .srst  (rst_i),
        .inc   (in_xfer && (res_code == 3'(gi))),
        .clr   (stat_clr_i),
        .value (cnt[gi])
      );
    end
  endgenerate

  ht_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_total_cnt (
    .clk   (clk_i),
    .srst  (rst_i),
    .inc   (in_xfer),
    .clr   (stat_clr_i),
    .value (cnt[HT_RES_STAT_ADDR_TOTAL])
  );

  // ---------------------------------------------------------------- read port
  // Sampling the counter outputs gives the pre-update value when a read
  // coincides with an increment or clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_reg <= '0;
      rd_val_reg  <= 1'b0;
    end else begin
      rd_val_reg <= stat_rd_en_i;
      if (stat_rd_en_i) begin
        rd_data_reg <= cnt[stat_rd_addr_i];
      end
    end
  end

  assign stat_rd_data_o = rd_data_reg;
  assign stat_rd_val_o  = rd_val_reg;

endmodule

// File: tb/tb_ht_res_stat.sv
module tb_ht_res_stat;
  import ht_res_stat_pkg::*;

  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    logic [1:0]             cmd;
    logic [2:0]             res;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [2:0]    rd_addr = 3'd0;
  logic          clr = 1'b0;
  logic [CW-1:0] rd_data;
  logic          rd_val;

  always #5 clk = ~clk;

  ht_res_if in_if ();
  ht_res_if out_if ();

  ht_res_stat #(.CNT_WIDTH(CW), .SLICE_EN(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ht_res_in      (in_if),
    .ht_res_out     (out_if),
    .stat_rd_en_i   (rd_en),
    .stat_rd_addr_i (rd_addr),
    .stat_rd_data_o (rd_data),
    .stat_rd_val_o  (rd_val),
    .stat_clr_i     (clr)
  );

  // Reference model: queue of accepted-but-undelivered beats, plain counts.
  beat_t q[$];
  int    mcnt [8];
  bit    rd_pend;
  int    rd_exp;
  int    rd_last;
  bit    chk_en;
  int    pass_cnt = 0;
  int    chk_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic beat_t cur_in();
    beat_t b;
    b.key   = in_if.key;
    b.value = in_if.value;
    b.cmd   = in_if.cmd;
    b.res   = in_if.res;
    return b;
  endfunction

  function automatic beat_t cur_out();
    beat_t b;
    b.key   = out_if.key;
    b.value = out_if.value;
    b.cmd   = out_if.cmd;
    b.res   = out_if.res;
    return b;
  endfunction

  // One clock cycle: check DUT against the model at the negedge, advance
  // the model by what the coming edge will do, then return at posedge+1.
  task automatic step();
    bit exp_ready;
    bit in_acc;
    bit out_acc;
    int r;
    @(negedge clk);
    exp_ready = (q.size() == 0) || out_if.ready;
    if (rd_pend) rd_last = rd_exp;
    if (chk_en) begin
      check("in_ready", in_if.ready, exp_ready);
      check("out_valid", out_if.valid, q.size() != 0);
      if (q.size() != 0) check("out_beat", cur_out(), q[0]);
      check("rd_val", rd_val, rd_pend);
      check("rd_data", rd_data, rd_last);
    end
    if (rst) begin
      q.delete();
      foreach (mcnt[i]) mcnt[i] = 0;
      rd_pend = 1'b0;
      rd_last = 0;
    end else begin
      in_acc  = in_if.valid && exp_ready;
      out_acc = (q.size() != 0) && out_if.ready;
      rd_pend = rd_en;
      if (rd_en) rd_exp = mcnt[rd_addr];
      if (clr) foreach (mcnt[i]) mcnt[i] = 0;
      if (in_acc) begin
        r = int'(in_if.res);
        if (r < HT_RES_NUM_CODES && mcnt[r] < MAXV) mcnt[r]++;
        if (mcnt[7] < MAXV) mcnt[7]++;
      end
      if (out_acc) begin
        $display("beat out key=%h value=%h cmd=%0d res=%0d", q[0].key, q[0].value, q[0].cmd, q[0].res);
        void'(q.pop_front());
      end
      if (in_acc) q.push_back(cur_in());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int res, input logic [15:0] key);
    in_if.valid = 1'b1;
    in_if.key   = key;
    in_if.value = 16'($urandom);
    in_if.cmd   = ht_cmd_t'(2'($urandom_range(0, 2)));
    in_if.res   = ht_res_t'(3'(res));
    step();
  endtask

  task automatic idle();
    in_if.valid = 1'b0;
    step();
  endtask

  task automatic read_expect(input logic [2:0] addr, input int exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = addr;
    step();
    rd_en = 1'b0;
    check(tag, rd_data, exp);
    check("rd_val_pulse", rd_val, 1'b1);
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.key    = '0;
    in_if.value  = '0;
    in_if.cmd    = CMD_SEARCH;
    in_if.res    = SEARCH_FOUND;
    out_if.ready = 1'b1;
    foreach (mcnt[i]) mcnt[i] = 0;
    rd_pend = 1'b0;
    rd_last = 0;
    rd_exp  = 0;
    chk_en  = 1'b0;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_in_ready", in_if.ready, 1'b1);
    check("rst_rd_val", rd_val, 1'b0);
    check("rst_rd_data", rd_data, 0);
    idle();

    // Back-to-back results with the consumer always ready
    send(0, 16'h0101);
    send(0, 16'h0202);
    send(2, 16'h0303);
    send(6, 16'h0404);
    idle();
    idle();
    read_expect(3'd0, 2, "b2b_search_found");
    read_expect(3'd2, 1, "b2b_insert_success");
    read_expect(3'd6, 1, "b2b_delete_miss");
    read_expect(3'd7, 4, "b2b_total");

    // Backpressure: consumer stalls, output holds the first beat
    out_if.ready = 1'b0;
    send(5, 16'h1234);
    in_if.key = 16'h5678;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold_key", out_if.key, 16'h1234);
      check("stall_in_ready", in_if.ready, 1'b0);
    end
    out_if.ready = 1'b1;
    step();
    check("release_next_key", out_if.key, 16'h5678);
    idle();
    idle();
    read_expect(3'd7, 6, "bp_total");

    // Saturation
    clr = 1'b1;
    idle();
    clr = 1'b0;
    for (int i = 0; i < 17; i++) send(4, 16'(i));
    idle();
    idle();
    read_expect(3'd4, MAXV, "sat_table_full");
    read_expect(3'd7, MAXV, "sat_total");

    // Clear coincident with an input transfer
    clr = 1'b1;
    idle();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) send(1, 16'h2000 + 16'(i));
    clr = 1'b1;
    send(1, 16'h2100);
    clr = 1'b0;
    idle();
    idle();
    read_expect(3'd1, 1, "clr_inc_code1");
    read_expect(3'd7, 1, "clr_inc_total");
    for (int a = 0; a < 7; a++) begin
      if (a != 1) read_expect(3'(a), 0, "clr_other_code");
    end

    // Read coincident with an increment of code 0
    clr = 1'b1;
    idle();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 16'h3000 + 16'(i));
    idle();
    rd_en   = 1'b1;
    rd_addr = 3'd0;
    send(0, 16'h3100);
    rd_en = 1'b0;
    in_if.valid = 1'b0;
    check("rd_pre_update", rd_data, 3);
    check("rd_pre_update_val", rd_val, 1'b1);
    idle();
    read_expect(3'd0, 4, "rd_post_update");

    // Reset while the slice holds a stalled beat
    out_if.ready = 1'b0;
    send(5, 16'h4444);
    in_if.valid = 1'b0;
    idle();
    check("held_before_rst", out_if.valid, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("rst_drop_valid", out_if.valid, 1'b0);
    out_if.ready = 1'b1;
    for (int a = 0; a < 8; a++) read_expect(3'(a), 0, "rst_cnt_zero");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_if.valid  = ($urandom_range(0, 3) != 0);
      in_if.key    = 16'($urandom);
      in_if.value  = 16'($urandom);
      in_if.cmd    = ht_cmd_t'(2'($urandom_range(0, 2)));
      in_if.res    = ht_res_t'(3'($urandom_range(0, 7)));
      out_if.ready = ($urandom_range(0, 3) != 0);
      rd_en        = ($urandom_range(0, 2) == 0);
      rd_addr      = 3'($urandom_range(0, 7));
      clr          = ($urandom_range(0, 19) == 0);
      step();
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    rd_en        = 1'b0;
    clr          = 1'b0;
    idle();
    idle();
    for (int a = 0; a < 8; a++) read_expect(3'(a), mcnt[a], "rand_final_cnt");
    idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ht_res_stat.md
Name: ht_res_stat

Overview:
- Sits directly downstream of the hash table result output, on the ht_res_if path.
- Passes every result transaction to the consumer through a one-stage register slice. The slice runs at full throughput.
- Keeps per-result-code saturating counters and a total counter, readable through a simple read port with clear-on-command.
- Gives software/debug visibility of search hits/misses, insert-full events and delete misses without disturbing the result stream.

Parameters:
- CNT_WIDTH, 32, width of each statistics counter.
- SLICE_EN, 1, 1 = registered pass-through; 0 = combinational pass-through with counters only.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- ht_res_in  interface  ht_res_if.slave  results from hash table (key, value, cmd, res, valid; drives ready).
- ht_res_out  interface  ht_res_if.master  results to consumer.
- stat_rd_en_i  input  1  counter read strobe.
- stat_rd_addr_i  input  3  counter index: 0..6 = ht_res_t encoding, 7 = total.
- stat_rd_data_o  output  CNT_WIDTH  read data.
- stat_rd_val_o  output  1  read data valid.
- stat_clr_i  input  1  clear all counters.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - ht_res_out.valid = 0.
  - ht_res_out key/value/cmd/res = 0.
  - All counters = 0.
  - stat_rd_val_o = 0, stat_rd_data_o = 0.
  - ht_res_in.ready is combinational and evaluates to 1 after reset.
- Input handshake: an input transfer occurs when ht_res_in.valid & ht_res_in.ready.
- Output handshake: an output transfer occurs when ht_res_out.valid & ht_res_out.ready.
- Slice (SLICE_EN=1):
  - ht_res_in.ready = ~ht_res_out.valid | ht_res_out.ready.
  - On an input transfer, load key/value/cmd/res into the output register and set valid=1.
  - On an output transfer with no input transfer, clear valid.
  - Latency is 1 cycle. Throughput is 1 transfer/cycle under continuous ready.
  - While ht_res_out.ready=0 and the slice is full, the input stalls. Held output data must not change.
- SLICE_EN=0: ht_res_out fields are wired directly from ht_res_in, and ht_res_in.ready = ht_res_out.ready.
- Counting:
  - Counting happens on the input transfer only.
  - On each input transfer, cnt[res] and cnt_total each increment by 1.
  - Counters saturate at all-ones and do not wrap.
  - A res encoding with no defined counter (out of 0..6) increments total only.
- Clear:
  - stat_clr_i=1 sets every counter to 0 on the next edge.
  - If clear and an input transfer fall in the same cycle, the affected counters and total are loaded with 1; the event is not lost.
  - Clear does not affect the data path.
- Read:
  - stat_rd_en_i registers cnt[stat_rd_addr_i] into stat_rd_data_o, and stat_rd_val_o=1 for exactly one cycle.
  - Read latency is 1 cycle.
  - A read in the same cycle as an increment or clear returns the pre-update value.
  - stat_rd_data_o holds its last value while stat_rd_val_o=0.
- Reset mid-operation: a held output beat is discarded (valid=0) and counters are zeroed. No partial state survives.

Decomposition:
- hash_table package:
  - Reuse KEY_WIDTH, VALUE_WIDTH, ht_cmd_t, ht_res_t.
  - Add HT_RES_STAT_ADDR_TOTAL = 3'd7.
  - Add a localparam for the count of defined ht_res_t codes (7).
- Sub-module ht_sat_cnt (CNT_WIDTH parameter; inc, clr, value):
  - Instantiated once per result code plus once for total.
  - Owns the saturate and clear+inc rules.
  - The slice logic stays in ht_res_stat.

Test Plan:
- Reset, then 4 back-to-back inputs with out.ready=1: SEARCH_FOUND ×2, INSERT_SUCCESS, DELETE_NOT_SUCCESS_NO_ENTRY.
  - Outputs appear 1 cycle later, identical and in order, one per cycle.
  - Reads of the 3 codes return 2, 1, 1. Read of total (addr 7) returns 4.
- Backpressure: out.ready=0 for 5 cycles while in.valid=1 with key=0x1234.
  - in.ready=0 after the first beat, and the output holds key 0x1234 stable.
  - Release: the next beat follows with no duplicate or drop.
  - Total counts only accepted beats.
- Saturation with CNT_WIDTH=4: 17 INSERT_NOT_SUCCESS_TABLE_IS_FULL results -> that counter reads 15, and total reads 15.
- Clear coincident with an input transfer of SEARCH_NOT_SUCCESS_NO_ENTRY, after prior counts of 5 -> that counter reads 1, total reads 1, all other codes read 0.
- Read coincident with an increment of code 0 (prior value 3):
  - stat_rd_data_o=3, with stat_rd_val_o high for one cycle.
  - The next read returns 4.
- Synchronous reset asserted while the slice holds a beat with out.ready=0 -> out.valid=0 on the next edge, and all counters read 0.
